// File: rtl/stream_demux_14_pkg.sv
// Shared constants and types for the stream_demux_14 1-to-4 demultiplexer.
// Optional per-lane transfer counters are enabled with the DEMUX_CNT_EN macro.
package demux_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef logic [SEL_W-1:0] lane_t;

endpackage : demux_pkg

// File: rtl/stream_demux_14_if.sv
// Handshake bundle between the producer, the demux and its four consumers.
// The slave modport is the demux side; master is the producer/consumer side.
interface stream_demux_14_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic                           mode;
  logic                           in_valid;
  logic                           in_ready;
  lane_t                          in_sel;
  logic [DATA_W-1:0]              in_data;
  logic [NUM_LANES-1:0]           out_valid;
  logic [NUM_LANES-1:0]           out_ready;
  logic [NUM_LANES*DATA_W-1:0]    out_data;

  modport slave (
    input  mode,
    input  in_valid,
    output in_ready,
    input  in_sel,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport master (
    output mode,
    output in_valid,
    input  in_ready,
    output in_sel,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );

endinterface : stream_demux_14_if

// File: rtl/stream_demux_14_lane_slot.sv
// One-entry output register for a single demux lane: holds one beat until
// the consumer takes it, and can reload in the same cycle it drains.
module demux_lane_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Next-state: a load wins over a drain so a same-cycle drain+load keeps the lane full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && drain) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  // Lane register; reset discards any beat held in the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : demux_lane_slot

// File: rtl/stream_demux_14.sv
// Registered 1-to-4 stream demultiplexer. Each accepted beat goes to the lane
// chosen by in_sel (DIRECT) or a rotating pointer (ROUND_ROBIN).
// Define DEMUX_CNT_EN to build saturating per-lane transfer counters.
module stream_demux_14
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  stream_demux_14_if.slave           bus,
  input  logic                       cnt_clr,
  output logic [NUM_LANES*CNT_W-1:0] cnt_o
);

  lane_t                 dst;
  lane_t                 rr_ptr_q;
  lane_t                 rr_ptr_d;
  logic                  accept;
  logic                  in_ready;
  logic [NUM_LANES-1:0]  lane_load;
  logic                  lane_valid [NUM_LANES];
  logic [DATA_W-1:0]     lane_data  [NUM_LANES];
  logic [NUM_LANES-1:0]  out_valid;

  // Destination select, head-of-line ready and per-lane load strobes.
  always_comb begin
    dst       = (bus.mode == MODE_RR) ? rr_ptr_q : bus.in_sel;
    in_ready  = ~out_valid[dst] | bus.out_ready[dst];
    accept    = bus.in_valid & in_ready;
    lane_load = '0;
    if (accept) begin
      lane_load[dst] = 1'b1;
    end
    rr_ptr_d = rr_ptr_q;
    if (accept && (bus.mode == MODE_RR)) begin
      rr_ptr_d = rr_ptr_q + lane_t'(1);
    end
  end

  // Round-robin pointer; it only advances on accepts made in ROUND_ROBIN mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_lane_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (lane_load[k]),
      .load_data (bus.in_data),
      .drain     (bus.out_ready[k]),
      .valid_o   (lane_valid[k]),
      .data_o    (lane_data[k])
    );
  end

  // Pack the per-lane slot outputs onto the flat output buses.
  always_comb begin
    out_valid    = '0;
    bus.out_data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      out_valid[k]                   = lane_valid[k];
      bus.out_data[k*DATA_W +: DATA_W] = lane_data[k];
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_LANES];
  logic [CNT_W-1:0] cnt_d [NUM_LANES];

  // Counter next-state: clear has priority, otherwise count handshakes up to saturation.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_clr) begin
        cnt_d[k] = '0;
      end else if (out_valid[k] && bus.out_ready[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Per-lane transfer counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Flatten the counters onto cnt_o, lane k in its own CNT_W slice.
  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign cnt_o          = '0;
`endif

endmodule : stream_demux_14

// File: tb/tb_stream_demux_14.sv
// Self-checking bench for stream_demux_14: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a lane model.
module tb_stream_demux_14;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 2;
  localparam int LANES   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   rst_n;
  logic                   cnt_clr;
  logic [LANES*CNT_W-1:0] cnt_o;

  int checks = 0;
  int errors = 0;

  stream_demux_14_if #(.DATA_W(DATA_W)) bus ();

  stream_demux_14 #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .cnt_o   (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: lane occupancy, lane contents, pointer and transfer counts.
  bit        chk_en = 1'b0;
  bit        m_full [LANES];
  logic [7:0] m_data [LANES];
  int        m_ptr;
  int        m_cnt  [LANES];

  function automatic int m_dst();
    return (bus.mode == 1'b1) ? m_ptr : int'(bus.in_sel);
  endfunction

  function automatic bit m_in_ready();
    int d;
    d = m_dst();
    return (!m_full[d]) || (bus.out_ready[d] == 1'b1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [7:0] d,
                               input logic m, input logic [3:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.mode      = m;
    bus.out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model update on every rising edge, from the inputs held across that edge.
  always @(posedge clk) begin : model
    int  d;
    bit  acc;
    bit  hs;
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = 8'h00;
        m_cnt[k]  = 0;
      end
      m_ptr  = 0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      d   = m_dst();
      acc = bus.in_valid && m_in_ready();
      for (int k = 0; k < LANES; k++) begin
        hs = m_full[k] && bus.out_ready[k];
`ifdef DEMUX_CNT_EN
        if (cnt_clr) m_cnt[k] = 0;
        else if (hs && m_cnt[k] < CNT_MAX) m_cnt[k] = m_cnt[k] + 1;
`endif
        if (hs) m_full[k] = 1'b0;
      end
      if (acc) begin
        m_full[d] = 1'b1;
        m_data[d] = bus.in_data;
        if (bus.mode) m_ptr = (m_ptr + 1) % LANES;
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin : compare
    logic [3:0] ev;
    logic [7:0] ec;
    if (chk_en) begin
      ev = '0;
      ec = '0;
      for (int k = 0; k < LANES; k++) begin
        ev[k] = m_full[k];
        ec[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        checkOutput($sformatf("lane%0d_data", k), 32'(bus.out_data[k*DATA_W +: DATA_W]), 32'(m_data[k]));
      end
      checkOutput("out_valid", 32'(bus.out_valid), 32'(ev));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
      checkOutput("cnt_o", 32'(cnt_o), 32'(ec));
    end
  end

  initial begin
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    applyStimulus(1'b1, 2'd0, 8'hFF, 1'b0, 4'hF);

    // Reset held for two edges with in_valid asserted
    repeat (2) step();
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset_out_data", bus.out_data, 32'h0);
    checkOutput("reset_cnt_o", 32'(cnt_o), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    step();

    // DIRECT routing to lane 2
    applyStimulus(1'b1, 2'd2, 8'hA5, 1'b0, 4'hF);
    step();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    checkOutput("direct_out_valid", 32'(bus.out_valid), 32'h4);
    checkOutput("direct_out_data", bus.out_data, 32'h00A50000);
    step();

    // Backpressure on lane 1, then same-cycle drain and reload
    applyStimulus(1'b1, 2'd1, 8'h3C, 1'b0, 4'b1101);
    step();
    applyStimulus(1'b1, 2'd1, 8'hC3, 1'b0, 4'b1101);
    #1;
    checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
    step();
    checkOutput("bp_lane1_hold", 32'(bus.out_data[15:8]), 32'h3C);
    checkOutput("bp_lane1_valid", 32'(bus.out_valid[1]), 32'h1);
    applyStimulus(1'b1, 2'd1, 8'hC3, 1'b0, 4'b0010);
    #1;
    checkOutput("bp_in_ready_high", 32'(bus.in_ready), 32'h1);
    step();
    checkOutput("reload_lane1_data", 32'(bus.out_data[15:8]), 32'hC3);
    checkOutput("reload_lane1_valid", 32'(bus.out_valid[1]), 32'h1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    step();

    // ROUND_ROBIN: six beats rotate through lanes 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'd3, 8'(8'h10 + i), 1'b1, 4'hF);
      step();
      checkOutput($sformatf("rr_beat%0d_valid", i), 32'(bus.out_valid), 32'(1 << (i % 4)));
      checkOutput($sformatf("rr_beat%0d_data", i),
                  32'(bus.out_data[(i % 4)*DATA_W +: DATA_W]), 32'(8'h10 + i));
    end
    applyStimulus(1'b1, 2'd0, 8'h16, 1'b1, 4'hF);
    step();
    checkOutput("rr_ptr_at_2", 32'(bus.out_valid), 32'h4);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    step();

    // Mid-operation reset with lanes 0 and 3 full
    applyStimulus(1'b1, 2'd0, 8'h55, 1'b0, 4'h0);
    step();
    applyStimulus(1'b1, 2'd3, 8'h66, 1'b0, 4'h0);
    step();
    checkOutput("pre_reset_valid", 32'(bus.out_valid), 32'h9);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
    rst_n = 1'b0;
    step();
    checkOutput("midreset_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midreset_data", bus.out_data, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd2, 8'h77, 1'b1, 4'h0);
    step();
    checkOutput("post_reset_rr_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("post_reset_rr_data", 32'(bus.out_data[7:0]), 32'h77);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    step();

    // Counter saturation on lane 0, then clear
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd0, 8'(8'h80 + i), 1'b0, 4'hF);
      step();
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    repeat (2) step();
`ifdef DEMUX_CNT_EN
    checkOutput("cnt_lane0_sat", 32'(cnt_o[1:0]), 32'h3);
`else
    checkOutput("cnt_lane0_off", 32'(cnt_o), 32'h0);
`endif
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checkOutput("cnt_cleared", 32'(cnt_o), 32'h0);

    // Randomized traffic checked by the model each cycle
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom));
      cnt_clr = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 63) != 0);
      step();
    end
    rst_n   = 1'b1;
    cnt_clr = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    repeat (3) step();

    $display("[TB] stimulus complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stream_demux_14
